// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, datapath widths and the default boot address.
package ifu_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;

    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h8000_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        ERR   = 2'd2
    } ifu_state_t;

    // Sequential successor; wraps modulo 2^32 by construction.
    function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/ifu_if.sv
// Fetch-side bus: instruction memory read port plus the decode handshake.
// master = fetch unit, slave = memory/decode environment.
interface ifu_if;
    import ifu_pkg::*;

    logic              imem_ren;
    logic [XLEN-1:0]   imem_raddr;
    logic [INST_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [INST_W-1:0] out_inst;
    logic              fetch_exc;

    modport master (
        output imem_ren, imem_raddr, out_valid, out_pc, out_inst, fetch_exc,
        input  imem_rdata, out_ready
    );

    modport slave (
        input  imem_ren, imem_raddr, out_valid, out_pc, out_inst, fetch_exc,
        output imem_rdata, out_ready
    );

endinterface

// File: rtl/ifu.sv
// Instruction fetch unit: sequential pc stream with redirect; optional misaligned-target trap (IFU_MISALIGN_CHECK_EN).
// Latency: fetch issued -> out_valid next cycle; redirect -> out_valid exactly 1 cycle; 1 instr/cycle when streaming.
// Backpressure: out_ready low holds pc/state and stops reads; memory output holds so out_inst stays stable.
module ifu
    import ifu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    ifu_if.master           bus
);

    ifu_state_t      state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic            ren;
    logic [XLEN-1:0] raddr;
    logic            vld;
    logic            exc;
    logic            misalign;

`ifdef IFU_MISALIGN_CHECK_EN
    assign misalign = |redirect_pc[1:0];
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state;
        pc_d    = pc;
        ren     = 1'b0;
        raddr   = pc;
        vld     = 1'b0;
        exc     = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
        exc     = (state == ERR) && !reset;
`endif
        if (reset) begin
            state_d = IDLE;
            pc_d    = RESET_VECTOR;
        end else if (redirect_valid) begin
            // Redirect wins over any fire this cycle: the wrong-path word is never presented.
            pc_d = redirect_pc;
            if (misalign) begin
                state_d = ERR;
            end else begin
                ren     = 1'b1;
                raddr   = redirect_pc;
                state_d = VALID;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_en) begin
                        ren     = 1'b1;
                        state_d = VALID;
                    end
                end
                VALID: begin
                    vld = 1'b1;
                    if (bus.out_ready) begin
                        pc_d = pc_inc(pc);
                        if (fetch_en) begin
                            ren   = 1'b1;
                            raddr = pc_inc(pc);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                ERR: begin
                    state_d = ERR;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_VECTOR;
        end else begin
            state <= state_d;
            pc    <= pc_d;
        end
    end

    assign bus.imem_ren   = ren;
    assign bus.imem_raddr = raddr;
    assign bus.out_valid  = vld;
    assign bus.out_pc     = pc;
    assign bus.out_inst   = bus.imem_rdata;
    assign bus.fetch_exc  = exc;

endmodule

// File: tb/tb_ifu.sv
// Scoreboard bench for ifu: stimulus queues expected read addresses and fired pcs, a negedge monitor pops and compares.
module tb_ifu;

    logic        clock;
    logic        reset;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    ifu_if bus();

    ifu #(.RESET_VECTOR(32'h8000_0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] rd_q[$];
    logic [31:0] fire_q[$];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    // Memory model: one-cycle read latency, output holds while ren is low.
    initial bus.imem_rdata = 32'h0;
    always @(posedge clock) begin
        if (bus.imem_ren) bus.imem_rdata <= inst_of(bus.imem_raddr);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (bus.imem_ren) begin
                if (rd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_read: got raddr %h expected no read at %0t", bus.imem_raddr, $time);
                end else begin
                    chk("raddr", bus.imem_raddr, rd_q.pop_front());
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (fire_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fire: got pc %h expected no fire at %0t", bus.out_pc, $time);
                end else begin
                    logic [31:0] epc;
                    epc = fire_q.pop_front();
                    chk("fire_pc", bus.out_pc, epc);
                    chk("fire_inst", bus.out_inst, inst_of(epc));
                end
            end
        end
    end

    task automatic cyc(input logic fe, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(posedge clock);
        #1;
        fetch_en       = fe;
        bus.out_ready  = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    task automatic sample;
        @(negedge clock);
        #1;
    endtask

    initial begin
        reset          = 1'b1;
        fetch_en       = 1'b1;
        bus.out_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h1234_5670;

        // Reset with a concurrent redirect: reset must win.
        sample();
        chk("rst_ren", {31'b0, bus.imem_ren}, 32'd0);
        chk("rst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst_exc", {31'b0, bus.fetch_exc}, 32'd0);
        @(posedge clock);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        reset = 1'b0;
        sample();
        chk("idle_raddr", bus.imem_raddr, 32'h8000_0000);
        chk("idle_valid", {31'b0, bus.out_valid}, 32'd0);

        // Streaming fetch, one fire per cycle.
        cyc(1'b1, 1'b1, 1'b0, 32'h0); rd_q.push_back(32'h8000_0000);
        sample();
        chk("first_valid", {31'b0, bus.out_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0); rd_q.push_back(32'h8000_0004); fire_q.push_back(32'h8000_0000);
        cyc(1'b1, 1'b1, 1'b0, 32'h0); rd_q.push_back(32'h8000_0008); fire_q.push_back(32'h8000_0004);

        // Backpressure for three cycles at 8000_0008.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 32'h0);
            sample();
            chk("stall_ren", {31'b0, bus.imem_ren}, 32'd0);
            chk("stall_raddr", bus.imem_raddr, 32'h8000_0008);
            chk("stall_pc", bus.out_pc, 32'h8000_0008);
            chk("stall_inst", bus.out_inst, inst_of(32'h8000_0008));
        end
        cyc(1'b1, 1'b1, 1'b0, 32'h0); rd_q.push_back(32'h8000_000C); fire_q.push_back(32'h8000_0008);

        // Redirect together with ready: no fire, target fetched.
        cyc(1'b1, 1'b1, 1'b1, 32'h8000_0100); rd_q.push_back(32'h8000_0100);
        sample();
        chk("redir_valid", {31'b0, bus.out_valid}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); fire_q.push_back(32'h8000_0100);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        sample();
        chk("to_idle_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("to_idle_raddr", bus.imem_raddr, 32'h8000_0104);
        cyc(1'b1, 1'b0, 1'b0, 32'h0); rd_q.push_back(32'h8000_0104);
        cyc(1'b1, 1'b1, 1'b0, 32'h0); rd_q.push_back(32'h8000_0108); fire_q.push_back(32'h8000_0104);

        // Wrap at the top of the address space.
        cyc(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC); rd_q.push_back(32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 1'b0, 32'h0); rd_q.push_back(32'h0000_0000); fire_q.push_back(32'hFFFF_FFFC);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        sample();
        chk("wrap_pc", bus.out_pc, 32'h0000_0000);
        chk("wrap_valid", {31'b0, bus.out_valid}, 32'd1);

        // Reset while VALID discards the in-flight instruction.
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        reset = 1'b1;
        sample();
        chk("midrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst_ren", {31'b0, bus.imem_ren}, 32'd0);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        reset = 1'b0;
        sample();
        chk("postrst_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("postrst_raddr", bus.imem_raddr, 32'h8000_0000);

`ifdef IFU_MISALIGN_CHECK_EN
        cyc(1'b0, 1'b1, 1'b1, 32'h8000_0102);
        sample();
        chk("mis_valid", {31'b0, bus.out_valid}, 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        sample();
        chk("err_exc", {31'b0, bus.fetch_exc}, 32'd1);
        chk("err_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("err_raddr", bus.imem_raddr, 32'h8000_0102);
        cyc(1'b1, 1'b1, 1'b1, 32'h8000_0306);
        cyc(1'b1, 1'b1, 1'b0, 32'h0);
        sample();
        chk("err_stay_exc", {31'b0, bus.fetch_exc}, 32'd1);
        cyc(1'b0, 1'b1, 1'b1, 32'h8000_0200); rd_q.push_back(32'h8000_0200);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); fire_q.push_back(32'h8000_0200);
        sample();
        chk("err_clear_exc", {31'b0, bus.fetch_exc}, 32'd0);
`else
        cyc(1'b0, 1'b1, 1'b1, 32'h8000_0102); rd_q.push_back(32'h8000_0102);
        cyc(1'b0, 1'b1, 1'b0, 32'h0); fire_q.push_back(32'h8000_0102);
        sample();
        chk("noerr_exc", {31'b0, bus.fetch_exc}, 32'd0);
`endif

        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        sample();
        chk("rd_q_drained", rd_q.size(), 32'd0);
        chk("fire_q_drained", fire_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
